// File: rtl/xor_share_sched_pkg.sv
// Shared types and helpers for the shared switch-level XOR scheduler.
package xor_share_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Bit width able to hold 0..v-1, never narrower than one bit.
  function automatic int unsigned wbits(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/xor_cell_sw.sv
// One-bit static CMOS XOR built from pmos/nmos switches between supply rails.
module xor_cell_sw (
  input  logic a,
  input  logic b,
  output wire  y
);

  supply1 vdd;
  supply0 gnd;

  // Switch-driven nodes carry several drivers, so they are resolved nets.
  wire na;
  wire nb;
  wire pu1;
  wire pu2;
  wire pd1;
  wire pd2;

  // Input inverters.
  pmos p_ina (na, vdd, a);
  nmos n_ina (na, gnd, a);
  pmos p_inb (nb, vdd, b);
  nmos n_inb (nb, gnd, b);

  // Pull-up: y high for a=1,b=0 or a=0,b=1.
  pmos p_u1a (pu1, vdd, na);
  pmos p_u1b (y,   pu1, b);
  pmos p_u2a (pu2, vdd, a);
  pmos p_u2b (y,   pu2, nb);

  // Pull-down: y low for a=b=1 or a=b=0.
  nmos n_d1a (pd1, gnd, a);
  nmos n_d1b (y,   pd1, b);
  nmos n_d2a (pd2, gnd, na);
  nmos n_d2b (y,   pd2, nb);

endmodule

// File: rtl/xor_share_sched.sv
// Round-robin scheduler sharing one bit-serial switch-level XOR cell
// among N_REQ requesters; results returned with the winner's index.
module xor_share_sched
  import xor_share_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [wbits(N_REQ)-1:0]  rsp_id,
  output logic                     busy
);

  localparam int unsigned ID_W  = wbits(N_REQ);
  localparam int unsigned SUM_W = ID_W + 1;
  localparam int unsigned CNT_W = wbits(WIDTH);

  state_t            state;
  state_t            state_nx;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  res_sh;
  logic              xbit;
  logic [SUM_W-1:0]  cand;

  // The only XOR on the datapath: transistor-level cell on the shifter LSBs.
  xor_cell_sw u_cell (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .y (xbit)
  );

  // Round-robin search from rr_ptr upward, plus operand mux for the winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand >= SUM_W'(N_REQ)) cand = cand - SUM_W'(N_REQ);
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == winner) begin
        sel_a = req_a[k*WIDTH +: WIDTH];
        sel_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (found) state_nx = S_SHIFT;
      S_SHIFT: if (cnt == CNT_W'(WIDTH - 1)) state_nx = S_DONE;
      S_DONE:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs: grant only in IDLE outside reset; response only in DONE.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !rst && found) req_ready[winner] = 1'b1;
    rsp_valid = (state == S_DONE);
    rsp_data  = rsp_valid ? res_sh : '0;
    rsp_id    = rsp_valid ? owner  : '0;
    busy      = (state == S_SHIFT) || (state == S_DONE);
  end

  // Datapath: operand capture, LSB-first shifting, round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            a_sh  <= sel_a;
            b_sh  <= sel_b;
            owner <= winner;
            cnt   <= '0;
          end
        end
        S_SHIFT: begin
          res_sh <= {xbit, res_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
        end
        S_DONE: begin
          if (rsp_ready)
            rr_ptr <= (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_sched.sv
// Scoreboard bench for xor_share_sched with a round-robin reference model.
module tb_xor_share_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;

  always #5 clk = ~clk;

  xor_share_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   id;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           m_ptr = 0;
  int           grant_cyc = -1000;
  int           last_grant = -1;
  bit           ready_const = 1'b0;
  logic [W-1:0] pa[N];
  logic [W-1:0] pb[N];

  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Reference: grant order for a set of requests held until served.
  function automatic void model_push(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int idx;
    pend = mask;
    idx = 0;
    while (pend != 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (pend[idx]) break;
      end
      sb.push_back('{data: pa[idx] ^ pb[idx], id: 2'(idx)});
      pend[idx] = 1'b0;
      m_ptr = (idx + 1) % N;
    end
  endfunction

  // Monitor: checks grants, latency, hold under backpressure, results.
  logic         prev_valid = 1'b0;
  logic         prev_acc = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [1:0]   prev_id = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("ready_in_reset", 32'(req_ready), 32'd0);
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (req_ready != 0) begin
        if (sb.size() == 0) chk("grant_unexpected", 32'(req_ready), 32'd0);
        else chk("grant_id", 32'(req_ready), 32'd1 << sb[0].id);
        chk("grant_has_valid", 32'(req_ready & ~req_valid), 32'd0);
        chk("grant_not_busy", 32'(busy), 32'd0);
        if (ready_const && last_grant >= 0)
          chk("issue_interval", 32'(cyc - last_grant), 32'(W + 2));
        last_grant = cyc;
        grant_cyc  = cyc;
      end
      if (busy) chk("ready_while_busy", 32'(req_ready), 32'd0);
      if (prev_acc) begin
        chk("idle_after_accept_busy", 32'(busy), 32'd0);
        chk("idle_after_accept_valid", 32'(rsp_valid), 32'd0);
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_data", 32'(rsp_data), 32'(prev_data));
        chk("hold_id", 32'(rsp_id), 32'(prev_id));
      end
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) chk("spurious_rsp", 32'(rsp_valid), 32'd0);
        else chk("latency", 32'(cyc - grant_cyc), 32'(W + 1));
      end
      if (rsp_valid) chk("busy_in_done", 32'(busy), 32'd1);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
        end
      end
      prev_valid = rsp_valid;
      prev_acc   = rsp_valid && rsp_ready;
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_id    = rsp_id;
    end
  end

  // mode 0: rsp_ready held high; 1: random; 2: first result stalled 5 cycles.
  task automatic run_phase(input logic [N-1:0] mask, input int mode);
    logic [N-1:0] g;
    logic         sawv;
    int           stall;
    bit           done;
    model_push(mask);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = pa[i];
      req_b[i*W +: W] = pb[i];
    end
    req_valid   = mask;
    last_grant  = -1;
    ready_const = (mode == 0);
    rsp_ready   = (mode != 2);
    stall       = 0;
    done        = 1'b0;
    for (int guard = 0; guard < 2000 && !done; guard++) begin
      @(negedge clk);
      g    = req_ready & req_valid;
      sawv = rsp_valid;
      if (sawv && !rsp_ready) stall++;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~g;
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          req_a[i*W +: W] = W'($urandom);
          req_b[i*W +: W] = W'($urandom);
        end
      end
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = (stall >= 5);
      endcase
      if (req_valid == 0 && sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      chk("phase_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
      req_valid = '0;
    end
    chk("rr_ptr", 32'(dut.rr_ptr), 32'(m_ptr));
    rsp_ready   = 1'b1;
    ready_const = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pa[i] = a;
    pb[i] = b;
  endtask

  initial begin
    bit got;
    int id;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rr_ptr", 32'(dut.rr_ptr), 32'd0);

    // Request pending while reset is held must not be granted.
    @(posedge clk);
    #1;
    set_op(0, 8'hA5, 8'h3C);
    req_a[W-1:0] = pa[0];
    req_b[W-1:0] = pb[0];
    req_valid = 4'b0001;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single request.
    run_phase(4'b0001, 0);

    // Full contention.
    for (int i = 0; i < N; i++) set_op(i, W'(i), 8'hF0);
    run_phase(4'b1111, 0);

    // Wrap-around: pointer to 3, then 0 beats 2, then 3 wraps pointer to 0.
    set_op(2, 8'h12, 8'h34);
    run_phase(4'b0100, 0);
    set_op(0, 8'h0F, 8'hFF);
    set_op(2, 8'h55, 8'hAA);
    run_phase(4'b0101, 0);
    set_op(3, 8'hC3, 8'h81);
    run_phase(4'b1000, 0);

    // Backpressure with a second request waiting.
    set_op(1, 8'h5A, 8'h0F);
    set_op(3, 8'h77, 8'h11);
    run_phase(4'b1010, 2);

    // Boundary data and bit ordering.
    set_op(0, 8'hFF, 8'hFF);
    run_phase(4'b0001, 0);
    set_op(1, 8'h00, 8'hFF);
    run_phase(4'b0010, 0);
    set_op(2, 8'h80, 8'h01);
    run_phase(4'b0100, 0);

    // Random traffic.
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
      run_phase(N'($urandom_range(1, 15)), $urandom_range(0, 1));
    end

    // Reset in the middle of SHIFT at cnt=4.
    id = m_ptr;
    set_op(id, 8'hE7, 8'h18);
    model_push(N'(1) << id);
    req_a[id*W +: W] = pa[id];
    req_b[id*W +: W] = pb[id];
    req_valid = N'(1) << id;
    rsp_ready = 1'b1;
    last_grant = -1;
    got = 1'b0;
    for (int guard = 0; guard < 50 && !got; guard++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) chk("rst_test_grant", 32'(req_ready), 32'd1 << id);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("cnt_before_reset", 32'(dut.cnt), 32'd4);
    chk("busy_before_reset", 32'(busy), 32'd1);
    sb.delete();
    m_ptr = 0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    repeat (W + 5) @(posedge clk);
    #1;

    // Normal service resumes from pointer 0.
    set_op(1, 8'h3C, 8'hC3);
    set_op(2, 8'h01, 8'h02);
    run_phase(4'b0110, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
